// File: rtl/sad_best_match.sv
// Block-SAD accumulator and best-candidate tracker for motion estimation.
// Optional early rejection counter enabled by SAD_BEST_MATCH_EARLY_TERM_EN.
module sad_best_match #(
    parameter int SAD_WIDTH = 10,
    parameter int ROWS      = 4,
    parameter int NUM_CAND  = 8,
    localparam int ACC_W    = SAD_WIDTH + $clog2(ROWS),
    localparam int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sad_valid,
    input  logic [SAD_WIDTH-1:0] sad_in,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     best_sad,
    output logic [IDX_W-1:0]     best_idx,
    output logic [IDX_W-1:0]     cand_idx
`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
    ,
    output logic [IDX_W:0]       early_term_cnt
`endif
);

    localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ACC_W-1:0] SAD_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [RC_W-1:0]  ROW_LAST = RC_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [RC_W-1:0]   row_cnt_r;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  block_s;
    logic              last_row_s;
    logic              last_cand_s;
    logic              better_s;
    logic              compare_en_s;

    assign block_s     = acc_r + ACC_W'(sad_in);
    assign last_row_s  = (row_cnt_r == ROW_LAST);
    assign last_cand_s = (cand_idx == CAND_LAST);
    assign better_s    = (block_s < best_sad);

`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
    logic rej_r;
    logic reject_now_s;

    // A rejected candidate can never beat best_sad, so skipping its compare leaves results unchanged.
    assign reject_now_s = !rej_r && (best_sad != SAD_MAX) && (block_s >= best_sad);
    assign compare_en_s = !rej_r;

    // Rejection flag and per-search rejection counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_r          <= 1'b0;
            early_term_cnt <= {(IDX_W+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    rej_r <= 1'b0;
                    if (start) begin
                        early_term_cnt <= {(IDX_W+1){1'b0}};
                    end
                end
                ACCUM: begin
                    if (sad_valid) begin
                        if (reject_now_s) begin
                            early_term_cnt <= early_term_cnt + (IDX_W+1)'(1'b1);
                        end
                        if (last_row_s) begin
                            rej_r <= 1'b0;
                        end else if (reject_now_s) begin
                            rej_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    rej_r <= 1'b0;
                end
            endcase
        end
    end
`else
    assign compare_en_s = 1'b1;
`endif

    // Search controller: row accumulation, candidate compare and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_sad  <= SAD_MAX;
            best_idx  <= {IDX_W{1'b0}};
            cand_idx  <= {IDX_W{1'b0}};
            row_cnt_r <= {RC_W{1'b0}};
            acc_r     <= ACC_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state_r   <= ACCUM;
                        busy      <= 1'b1;
                        acc_r     <= ACC_ZERO;
                        row_cnt_r <= {RC_W{1'b0}};
                        cand_idx  <= {IDX_W{1'b0}};
                        best_sad  <= SAD_MAX;
                    end
                end
                ACCUM: begin
                    done <= 1'b0;
                    if (sad_valid) begin
                        if (last_row_s) begin
                            acc_r     <= ACC_ZERO;
                            row_cnt_r <= {RC_W{1'b0}};
                            if (compare_en_s && better_s) begin
                                best_sad <= block_s;
                                best_idx <= cand_idx;
                            end
                            if (last_cand_s) begin
                                cand_idx <= {IDX_W{1'b0}};
                                state_r  <= DONE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                cand_idx <= cand_idx + IDX_W'(1'b1);
                            end
                        end else begin
                            acc_r     <= block_s;
                            row_cnt_r <= row_cnt_r + RC_W'(1'b1);
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_best_match.sv
// Scoreboard bench for sad_best_match with NUM_CAND=3; expected results queued at start, checked on done.
module tb_sad_best_match;

    localparam int SAD_WIDTH = 10;
    localparam int ROWS      = 4;
    localparam int NUM_CAND  = 3;
    localparam int ACC_W     = SAD_WIDTH + $clog2(ROWS);
    localparam int IDX_W     = $clog2(NUM_CAND);

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 sad_valid;
    logic [SAD_WIDTH-1:0] sad_in;
    logic                 busy;
    logic                 done;
    logic [ACC_W-1:0]     best_sad;
    logic [IDX_W-1:0]     best_idx;
    logic [IDX_W-1:0]     cand_idx;
`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
    logic [IDX_W:0]       early_term_cnt;
`endif

    typedef struct {
        int sad;
        int idx;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    sad_best_match #(
        .SAD_WIDTH(SAD_WIDTH),
        .ROWS(ROWS),
        .NUM_CAND(NUM_CAND)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .sad_valid(sad_valid),
        .sad_in(sad_in),
        .busy(busy),
        .done(done),
        .best_sad(best_sad),
        .best_idx(best_idx),
        .cand_idx(cand_idx)
`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
        ,
        .early_term_cnt(early_term_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_best_sad", int'(best_sad), e.sad);
                check("sb_best_idx", int'(best_idx), e.idx);
                check("sb_busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic do_start(input int exp_sad, input int exp_idx);
        exp_t e;
        e.sad = exp_sad;
        e.idx = exp_idx;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        sad_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_cand(input int a, input int b, input int c, input int d, input int stall);
        int v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            sad_valid = 1'b1;
            sad_in = SAD_WIDTH'(v[r]);
            if (r < 3) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    sad_valid = 1'b0;
                    sad_in = 10'h3ff;
                end
            end
        end
    endtask

    task automatic finish_rows();
        @(negedge clk);
        sad_valid = 1'b0;
        sad_in = 10'd0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sad_valid = 1'b0;
        sad_in = 10'd0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_best_sad", int'(best_sad), 4095);
        check("rst_best_idx", int'(best_idx), 0);
        check("rst_cand_idx", int'(cand_idx), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic search: block SADs 1029, 4, 0.
        do_start(0, 2);
        send_cand(4, 5, 0, 1020, 0);
        send_cand(1, 1, 1, 1, 0);
        send_cand(0, 0, 0, 0, 0);
        finish_rows();
        check("basic_done_latency", int'(done), 1);
        check("basic_busy_low", int'(busy), 0);
        wait_drain("basic_drain");
        // Rows presented while idle must not disturb the held result.
        send_cand(7, 7, 7, 7, 0);
        finish_rows();
        check("idle_hold_sad", int'(best_sad), 0);
        check("idle_hold_idx", int'(best_idx), 2);
        check("idle_no_busy", int'(busy), 0);

        // Tie between candidates 0 and 1 (both 10), with stalls.
        do_start(10, 0);
        send_cand(1, 2, 3, 4, 3);
        send_cand(4, 3, 2, 1, 3);
        send_cand(5, 5, 5, 5, 3);
        finish_rows();
        wait_drain("tie_stall_drain");
        // Same without stalls; a start held through DONE is ignored.
        do_start(10, 0);
        send_cand(1, 2, 3, 4, 0);
        send_cand(4, 3, 2, 1, 0);
        send_cand(5, 5, 5, 5, 0);
        finish_rows();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", int'(busy), 0);
        wait_drain("tie_nostall_drain");

        // Max-value block: 4 x 1023 = 4092 must not wrap.
        do_start(0, 1);
        send_cand(1023, 1023, 1023, 1023, 0);
        finish_rows();
        check("max_block_sad", int'(best_sad), 4092);
        check("max_block_idx", int'(best_idx), 0);
        check("max_cand_idx", int'(cand_idx), 1);
        send_cand(0, 0, 0, 0, 0);
        send_cand(1023, 1023, 1023, 1023, 0);
        finish_rows();
        wait_drain("max_drain");

        // start mid-search is ignored.
        do_start(0, 2);
        send_cand(4, 5, 0, 1020, 0);
        @(negedge clk);
        sad_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midstart_busy", int'(busy), 1);
        check("midstart_cand_idx", int'(cand_idx), 1);
        send_cand(1, 1, 1, 1, 0);
        send_cand(0, 0, 0, 0, 0);
        finish_rows();
        wait_drain("midstart_drain");

        // Reset mid-search aborts back to reset values.
        begin
            exp_t dummy;
            do_start(0, 2);
            dummy = sb_q.pop_back();
        end
        send_cand(4, 5, 0, 1020, 0);
        send_cand(3, 3, 3, 3, 0);
        @(negedge clk);
        sad_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_best_sad", int'(best_sad), 4095);
        check("midrst_best_idx", int'(best_idx), 0);
        check("midrst_cand_idx", int'(cand_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        do_start(0, 2);
        send_cand(4, 5, 0, 1020, 0);
        send_cand(1, 1, 1, 1, 0);
        send_cand(0, 0, 0, 0, 0);
        finish_rows();
        wait_drain("post_rst_drain");

`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
        do_start(4, 0);
        send_cand(1, 1, 1, 1, 0);
        send_cand(5, 0, 0, 0, 0);
        send_cand(2, 2, 2, 2, 0);
        finish_rows();
        check("early_term_cnt", int'(early_term_cnt), 2);
        wait_drain("early_term_drain");
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sad_best_match.md
Name: sad_best_match

Overview:
- Downstream consumer of the registered SAD tree in the motion-estimation datapath.
- Accepts one row SAD per valid cycle and accumulates ROWS rows into a candidate block SAD.
- Compares each candidate SAD against the running minimum over NUM_CAND candidates.
- Reports the best SAD and its candidate index, with a one-cycle done pulse.

Parameters:
- SAD_WIDTH, 10: width of incoming row SAD (8-bit pixels, 4 inputs per row).
- ROWS, 4: row SADs per candidate block.
- NUM_CAND, 8: candidates per search.
- Derived: ACC_W = SAD_WIDTH + $clog2(ROWS); IDX_W = $clog2(NUM_CAND), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a new search; sampled only in IDLE.
- sad_valid  in  1  sad_in carries a valid row SAD this cycle.
- sad_in  in  SAD_WIDTH  row SAD from the upstream SAD stage.
- busy  out  1  high while in ACCUM.
- done  out  1  one-cycle pulse when a search completes.
- best_sad  out  ACC_W  minimum block SAD found.
- best_idx  out  IDX_W  candidate index of best_sad.
- cand_idx  out  IDX_W  index of the candidate currently being accumulated.

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, best_sad=all ones, best_idx=0, cand_idx=0; row counter and accumulator cleared.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 -> ACCUM on the next edge; clears accumulator, row counter and cand_idx; sets best_sad to all ones.
  - sad_valid is ignored.
  - best_sad and best_idx hold the previous result.
- ACCUM:
  - Each sad_valid edge adds sad_in (zero-extended to ACC_W) and increments the row counter.
  - Cycles with sad_valid=0 are stalls: no state change.
  - On the ROWS-th valid row, block = acc + sad_in.
  - If block < best_sad (strictly less), then best_sad <= block and best_idx <= cand_idx. On a tie the earlier candidate is kept.
  - After the ROWS-th row: accumulator and row counter clear, and cand_idx increments.
  - If the candidate was the last one (cand_idx == NUM_CAND-1): go to DONE; cand_idx wraps to 0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start during DONE is ignored.
- Latency: best_sad and best_idx are final on the edge that accepts the last valid row. done is high during the cycle immediately after that edge.
- start while busy: ignored and does not restart. Only rst aborts a search; results then revert to reset values.
- Width: ACC_W holds the maximum possible block SAD without wrap: ROWS*(2^SAD_WIDTH-1) = 4092 for the defaults.
- Alignment: the upstream SAD stage has one cycle of register latency. The controller asserts sad_valid aligned to the registered SAD, not to the pixel inputs.

Optional Feature:
- Macro: SAD_BEST_MATCH_EARLY_TERM_EN.
- Defined:
  - Adds output port early_term_cnt, width IDX_W+1.
  - A candidate is marked rejected on the first valid row where acc + sad_in >= best_sad, provided best_sad is not all ones.
  - The remaining rows of that candidate are still consumed to keep alignment, but no compare or update occurs for it.
  - early_term_cnt increments once per rejected candidate, clears on start, and resets to 0.
  - best_sad and best_idx results are identical to the non-EN build.
- Undefined: port absent; every candidate completes a full compare.

Test Plan:
- Reset check: assert rst -> busy=0, done=0, best_sad=4095, best_idx=0, cand_idx=0, without needing a clock edge.
- Basic search (NUM_CAND=3): rows {4,5,0,1020}, {1,1,1,1}, {0,0,0,0} back-to-back -> best_sad=0, best_idx=2; done high the cycle after the 12th valid; busy low in that cycle.
- Tie and stalls (NUM_CAND=2): rows {1,2,3,4} and {4,3,2,1}, with sad_valid deasserted for 3 cycles between rows -> best_sad=10, best_idx=0; result identical to the no-stall run.
- Max value (NUM_CAND=2): all rows 1023 for candidate 0, then all rows 0 -> candidate-0 block SAD=4092 with no wrap; final best_sad=0, best_idx=1.
- Control: start pulsed mid-ACCUM -> ignored, result unchanged. rst asserted mid-ACCUM -> immediate IDLE with reset values. A following start plus the basic-search rows -> same result as the basic search.
- EARLY_TERM_EN build: candidates {1,1,1,1}, {5,0,0,0}, {2,2,2,2} -> best_sad=4, best_idx=0, early_term_cnt=2.
